// File: rtl/slant_mem_arbiter.sv
// Single-port arbiter for one slant Y/C bank: camera writes, HDMI and radio reads.
// Fixed priority wr > hd > tx, with tx promoted above hd after prolonged starvation.
module slant_mem_arbiter #(
  parameter int AW          = 18,
  parameter int DW          = 10,
  parameter int TX_MAX_WAIT = 8,
  parameter int STALL_W     = 16
) (
  input  logic               Cclk,
  input  logic               rstn,
  input  logic               frame_start,
  input  logic               wr_req,
  input  logic [AW-1:0]      wr_addr,
  input  logic [DW-1:0]      wr_data,
  output logic               wr_gnt,
  input  logic               hd_req,
  input  logic [AW-1:0]      hd_addr,
  output logic               hd_gnt,
  output logic [DW-1:0]      hd_rdata,
  output logic               hd_rvalid,
  input  logic               tx_req,
  input  logic [AW-1:0]      tx_addr,
  output logic               tx_gnt,
  output logic [DW-1:0]      tx_rdata,
  output logic               tx_rvalid,
  output logic               mem_en,
  output logic               mem_we,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_wdata,
  input  logic [DW-1:0]      mem_rdata,
  output logic [STALL_W-1:0] hd_stall_cnt,
  output logic               tx_promoted
);

  localparam int WAIT_W = $clog2(TX_MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TX_MAX_WAIT);

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_HD   = 2'd1,
    TAG_TX   = 2'd2
  } tag_t;

  tag_t              tag_grant;
  tag_t              tag_s1;
  tag_t              tag_s2;
  logic              any_gnt;
  logic [AW-1:0]     cmd_addr;
  logic [WAIT_W-1:0] tx_wait;
  logic [WAIT_W-1:0] tx_wait_next;
  logic              tx_promoted_next;

  // Grants use the registered promotion flag, so a frame_start cycle still arbitrates on the old value.
  always_comb begin
    wr_gnt    = 1'b0;
    hd_gnt    = 1'b0;
    tx_gnt    = 1'b0;
    tag_grant = TAG_NONE;
    cmd_addr  = tx_addr;
    if (wr_req) begin
      wr_gnt   = 1'b1;
      cmd_addr = wr_addr;
    end else if (tx_promoted && tx_req) begin
      tx_gnt    = 1'b1;
      tag_grant = TAG_TX;
    end else if (hd_req) begin
      hd_gnt    = 1'b1;
      tag_grant = TAG_HD;
      cmd_addr  = hd_addr;
    end else if (tx_req) begin
      tx_gnt    = 1'b1;
      tag_grant = TAG_TX;
    end
  end

  assign any_gnt = wr_gnt | hd_gnt | tx_gnt;

  always_comb begin
    tx_wait_next     = tx_wait;
    tx_promoted_next = tx_promoted;
    if (frame_start || !tx_req || tx_gnt) begin
      tx_wait_next     = '0;
      tx_promoted_next = 1'b0;
    end else begin
      if (tx_wait != WAIT_MAX)
        tx_wait_next = tx_wait + 1'b1;
      if (tx_wait_next == WAIT_MAX)
        tx_promoted_next = 1'b1;
    end
  end

  always_ff @(posedge Cclk or negedge rstn) begin
    if (!rstn) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= any_gnt;
      mem_we <= wr_gnt;
      if (any_gnt)
        mem_addr <= cmd_addr;
      if (wr_gnt)
        mem_wdata <= wr_data;
    end
  end

  // Owner tags follow each read through the command and memory stages so data returns to its issuer.
  always_ff @(posedge Cclk or negedge rstn) begin
    if (!rstn) begin
      tag_s1 <= TAG_NONE;
      tag_s2 <= TAG_NONE;
    end else begin
      tag_s1 <= tag_grant;
      tag_s2 <= tag_s1;
    end
  end

  always_ff @(posedge Cclk or negedge rstn) begin
    if (!rstn) begin
      hd_rdata  <= '0;
      hd_rvalid <= 1'b0;
      tx_rdata  <= '0;
      tx_rvalid <= 1'b0;
    end else begin
      hd_rvalid <= (tag_s2 == TAG_HD);
      tx_rvalid <= (tag_s2 == TAG_TX);
      if (tag_s2 == TAG_HD)
        hd_rdata <= mem_rdata;
      if (tag_s2 == TAG_TX)
        tx_rdata <= mem_rdata;
    end
  end

  always_ff @(posedge Cclk or negedge rstn) begin
    if (!rstn) begin
      tx_wait     <= '0;
      tx_promoted <= 1'b0;
    end else begin
      tx_wait     <= tx_wait_next;
      tx_promoted <= tx_promoted_next;
    end
  end

  always_ff @(posedge Cclk or negedge rstn) begin
    if (!rstn) begin
      hd_stall_cnt <= '0;
    end else if (frame_start) begin
      hd_stall_cnt <= '0;
    end else if (hd_req && !hd_gnt && (hd_stall_cnt != '1)) begin
      hd_stall_cnt <= hd_stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_slant_mem_arbiter.sv
// Directed bench for slant_mem_arbiter with a one-cycle-latency memory model.
module tb_slant_mem_arbiter;

  localparam int AW = 18;
  localparam int DW = 10;

  logic          Cclk;
  logic          rstn;
  logic          frame_start;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_gnt;
  logic          hd_req;
  logic [AW-1:0] hd_addr;
  logic          hd_gnt;
  logic [DW-1:0] hd_rdata;
  logic          hd_rvalid;
  logic          tx_req;
  logic [AW-1:0] tx_addr;
  logic          tx_gnt;
  logic [DW-1:0] tx_rdata;
  logic          tx_rvalid;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [15:0]   hd_stall_cnt;
  logic          tx_promoted;

  int assert_count;
  int fail_count;

  slant_mem_arbiter dut (
    .Cclk         (Cclk),
    .rstn         (rstn),
    .frame_start  (frame_start),
    .wr_req       (wr_req),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_gnt       (wr_gnt),
    .hd_req       (hd_req),
    .hd_addr      (hd_addr),
    .hd_gnt       (hd_gnt),
    .hd_rdata     (hd_rdata),
    .hd_rvalid    (hd_rvalid),
    .tx_req       (tx_req),
    .tx_addr      (tx_addr),
    .tx_gnt       (tx_gnt),
    .tx_rdata     (tx_rdata),
    .tx_rvalid    (tx_rvalid),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .hd_stall_cnt (hd_stall_cnt),
    .tx_promoted  (tx_promoted)
  );

  initial Cclk = 1'b0;
  always #5 Cclk = ~Cclk;

  // Memory content is a fixed scramble of the address so every read has a known answer.
  function automatic logic [DW-1:0] model_data(input logic [AW-1:0] a);
    return a[DW-1:0] ^ 10'h386;
  endfunction

  always @(posedge Cclk) begin
    if (mem_en && !mem_we)
      mem_rdata <= model_data(mem_addr);
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic w, input logic h, input logic t);
    wr_req = w;
    hd_req = h;
    tx_req = t;
  endtask

  task automatic tick();
    @(posedge Cclk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " mem_en"},       32'(mem_en), 0);
    checkOutput({tag, " mem_we"},       32'(mem_we), 0);
    checkOutput({tag, " mem_addr"},     32'(mem_addr), 0);
    checkOutput({tag, " mem_wdata"},    32'(mem_wdata), 0);
    checkOutput({tag, " hd_rdata"},     32'(hd_rdata), 0);
    checkOutput({tag, " hd_rvalid"},    32'(hd_rvalid), 0);
    checkOutput({tag, " tx_rdata"},     32'(tx_rdata), 0);
    checkOutput({tag, " tx_rvalid"},    32'(tx_rvalid), 0);
    checkOutput({tag, " hd_stall_cnt"}, 32'(hd_stall_cnt), 0);
    checkOutput({tag, " tx_promoted"},  32'(tx_promoted), 0);
  endtask

  initial begin
    assert_count = 0;
    fail_count   = 0;
    rstn         = 1'b0;
    frame_start  = 1'b0;
    wr_addr      = '0;
    wr_data      = '0;
    hd_addr      = '0;
    tx_addr      = '0;
    mem_rdata    = '0;
    applyStimulus(1'b0, 1'b0, 1'b0);

    repeat (2) @(posedge Cclk);
    @(negedge Cclk);
    checkAllZero("reset");
    tick();
    rstn = 1'b1;

    // Single HDMI read: grant, command one cycle later, data three cycles later.
    hd_addr = 18'h00123;
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      if (c == 1) applyStimulus(1'b0, 1'b0, 1'b0);
      @(negedge Cclk);
      if (c == 0) begin
        checkOutput("t1 hd_gnt", 32'(hd_gnt), 1);
        checkOutput("t1 wr_gnt", 32'(wr_gnt), 0);
        checkOutput("t1 tx_gnt", 32'(tx_gnt), 0);
      end
      if (c == 1) begin
        checkOutput("t1 mem_en", 32'(mem_en), 1);
        checkOutput("t1 mem_we", 32'(mem_we), 0);
        checkOutput("t1 mem_addr", 32'(mem_addr), 32'h123);
      end
      checkOutput("t1 hd_rvalid", 32'(hd_rvalid), (c == 3) ? 1 : 0);
      checkOutput("t1 tx_rvalid", 32'(tx_rvalid), 0);
      if (c == 3) checkOutput("t1 hd_rdata", 32'(hd_rdata), 32'h2A5);
      tick();
    end

    // Write always wins over both readers.
    for (int c = 0; c < 5; c++) begin
      if (c < 3) begin
        wr_addr = 18'h00200 + 18'(c);
        wr_data = 10'h0A0 + 10'(c);
        applyStimulus(1'b1, 1'b1, 1'b1);
      end else begin
        applyStimulus(1'b0, 1'b0, 1'b0);
      end
      frame_start = (c == 3);
      @(negedge Cclk);
      if (c < 3) begin
        checkOutput("t2 wr_gnt", 32'(wr_gnt), 1);
        checkOutput("t2 hd_gnt", 32'(hd_gnt), 0);
        checkOutput("t2 tx_gnt", 32'(tx_gnt), 0);
      end
      if (c >= 1 && c <= 3) begin
        checkOutput("t2 mem_we", 32'(mem_we), 1);
        checkOutput("t2 mem_addr", 32'(mem_addr), 32'h200 + 32'(c - 1));
        checkOutput("t2 mem_wdata", 32'(mem_wdata), 32'h0A0 + 32'(c - 1));
      end
      if (c == 3) checkOutput("t2 hd_stall_cnt", 32'(hd_stall_cnt), 3);
      if (c == 4) checkOutput("t2 stall cleared", 32'(hd_stall_cnt), 0);
      tick();
    end
    frame_start = 1'b0;

    // Starved tx gets promoted after eight hd grants.
    hd_addr = 18'h00040;
    tx_addr = 18'h00050;
    for (int c = 0; c < 13; c++) begin
      if (c == 0)  applyStimulus(1'b0, 1'b1, 1'b1);
      if (c == 10) applyStimulus(1'b0, 1'b0, 1'b0);
      @(negedge Cclk);
      if (c < 8) begin
        checkOutput("t3 hd_gnt", 32'(hd_gnt), 1);
        checkOutput("t3 tx_gnt", 32'(tx_gnt), 0);
        checkOutput("t3 tx_promoted", 32'(tx_promoted), 0);
      end else if (c == 8) begin
        checkOutput("t3 promoted", 32'(tx_promoted), 1);
        checkOutput("t3 tx_gnt promoted", 32'(tx_gnt), 1);
        checkOutput("t3 hd_gnt promoted", 32'(hd_gnt), 0);
      end else if (c == 9) begin
        checkOutput("t3 promoted cleared", 32'(tx_promoted), 0);
        checkOutput("t3 hd resumes", 32'(hd_gnt), 1);
        checkOutput("t3 tx_gnt after", 32'(tx_gnt), 0);
      end
      checkOutput("t3 hd_rvalid", 32'(hd_rvalid), ((c >= 3 && c <= 10) || c == 12) ? 1 : 0);
      checkOutput("t3 tx_rvalid", 32'(tx_rvalid), (c == 11) ? 1 : 0);
      if (c == 11) checkOutput("t3 tx_rdata", 32'(tx_rdata), 32'(model_data(18'h00050)));
      if (c == 12) checkOutput("t3 hd_rdata", 32'(hd_rdata), 32'(model_data(18'h00040)));
      tick();
    end

    // Alternating reads return in grant order to the correct owner.
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1'b0, (c == 0 || c == 2), (c == 1 || c == 3));
      hd_addr = (c == 0) ? 18'h00010 : 18'h00012;
      tx_addr = (c == 1) ? 18'h00011 : 18'h00013;
      @(negedge Cclk);
      if (c < 4) begin
        checkOutput("t4 hd_gnt", 32'(hd_gnt), (c == 0 || c == 2) ? 1 : 0);
        checkOutput("t4 tx_gnt", 32'(tx_gnt), (c == 1 || c == 3) ? 1 : 0);
      end
      checkOutput("t4 hd_rvalid", 32'(hd_rvalid), (c == 3 || c == 5) ? 1 : 0);
      checkOutput("t4 tx_rvalid", 32'(tx_rvalid), (c == 4 || c == 6) ? 1 : 0);
      if (c == 3) checkOutput("t4 hd_rdata 0x10", 32'(hd_rdata), 32'(model_data(18'h00010)));
      if (c == 4) begin
        checkOutput("t4 tx_rdata 0x11", 32'(tx_rdata), 32'(model_data(18'h00011)));
        checkOutput("t4 hd_rdata hold", 32'(hd_rdata), 32'(model_data(18'h00010)));
      end
      if (c == 5) checkOutput("t4 hd_rdata 0x12", 32'(hd_rdata), 32'(model_data(18'h00012)));
      if (c == 6) checkOutput("t4 tx_rdata 0x13", 32'(tx_rdata), 32'(model_data(18'h00013)));
      tick();
    end

    // Stall counter saturation and frame_start clear.
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    wr_addr = 18'h00300;
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (65534) tick();
    @(negedge Cclk);
    checkOutput("t5 stall 0xFFFE", 32'(hd_stall_cnt), 32'hFFFE);
    tick();
    @(negedge Cclk);
    checkOutput("t5 stall 0xFFFF", 32'(hd_stall_cnt), 32'hFFFF);
    repeat (3) tick();
    @(negedge Cclk);
    checkOutput("t5 stall saturated", 32'(hd_stall_cnt), 32'hFFFF);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    @(negedge Cclk);
    checkOutput("t5 stall frame clear", 32'(hd_stall_cnt), 0);
    tick();

    // Reset during an in-flight read discards it.
    repeat (4) tick();
    hd_addr = 18'h00077;
    applyStimulus(1'b0, 1'b1, 1'b0);
    @(negedge Cclk);
    checkOutput("t6 hd_gnt", 32'(hd_gnt), 1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    rstn = 1'b0;
    @(negedge Cclk);
    checkAllZero("t6 in reset");
    tick();
    rstn = 1'b1;
    hd_addr = 18'h00055;
    applyStimulus(1'b0, 1'b1, 1'b0);
    @(negedge Cclk);
    checkOutput("t6 grant after release", 32'(hd_gnt), 1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int c = 3; c < 7; c++) begin
      @(negedge Cclk);
      checkOutput("t6 hd_rvalid", 32'(hd_rvalid), (c == 5) ? 1 : 0);
      checkOutput("t6 tx_rvalid", 32'(tx_rvalid), 0);
      if (c == 5) checkOutput("t6 hd_rdata", 32'(hd_rdata), 32'(model_data(18'h00055)));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/slant_mem_arbiter.md
Name: slant_mem_arbiter

Overview:
- Single-port arbiter for one slant Y/C memory bank in the camera clock domain.
- Shares the bank between three requesters:
  - camera write stream (wr)
  - HDMI read path (hd)
  - radio transmit read path (tx)
- Fixed priority is wr > hd > tx, with anti-starvation promotion of tx over hd.
- Issues registered memory commands and returns tagged read data to the requester that issued the read. The design instantiates four of these, one per slant bank.

Parameters:
- AW, 18, memory word address width (covers 38400 words).
- DW, 10, memory data width ({Y[4:0],C[4:0]}).
- TX_MAX_WAIT, 8, consecutive denied tx cycles before tx is promoted above hd.
- STALL_W, 16, width of the hd stall statistics counter.

Ports:
- Cclk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse at camera frame start; clears starvation counter and statistics
- wr_req  in  1  write request; held until granted
- wr_addr  in  AW  write address
- wr_data  in  DW  write data
- wr_gnt  out  1  write accepted this cycle
- hd_req  in  1  HDMI read request; held until granted
- hd_addr  in  AW  HDMI read address
- hd_gnt  out  1  HDMI read accepted this cycle
- hd_rdata  out  DW  HDMI read data
- hd_rvalid  out  1  hd_rdata valid, 1-cycle pulse
- tx_req  in  1  transmit read request; held until granted
- tx_addr  in  AW  transmit read address
- tx_gnt  out  1  transmit read accepted this cycle
- tx_rdata  out  DW  transmit read data
- tx_rvalid  out  1  tx_rdata valid, 1-cycle pulse
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid one cycle after mem_en with mem_we=0
- hd_stall_cnt  out  STALL_W  saturating count of cycles with hd_req=1 and hd_gnt=0
- tx_promoted  out  1  tx currently holds promoted priority

Behaviour:
- Reset values:
  - All outputs are 0: mem_*, gnt's, rvalid's, rdata's, hd_stall_cnt, tx_promoted.
  - Internal tx_wait is 0 and both tag pipeline stages are empty.
- Grants are combinational from the request inputs and tx_promoted. At most one grant is asserted per cycle.
  - wr_req=1: wr_gnt=1. Write always wins; the camera stream is never stalled.
  - Else if tx_promoted=1 and tx_req=1: tx_gnt=1.
  - Else if hd_req=1: hd_gnt=1.
  - Else if tx_req=1: tx_gnt=1.
- Handshake:
  - The requester keeps req, addr and data stable until it sees gnt=1 in the same cycle.
  - A request withdrawn before grant is legal and is simply not served.
- Command stage:
  - On the edge ending grant cycle N, mem_en, mem_we, mem_addr and mem_wdata register the granted command.
  - mem_we=1 only for wr.
  - With no grant, mem_en=0 and mem_we=0; mem_addr and mem_wdata hold their last values.
- Tag pipeline: a 2-bit owner tag (none/hd/tx) travels with each read.
  - Stage 1 is aligned with mem_en in cycle N+1.
  - Stage 2 is aligned with mem_rdata in cycle N+2.
- Return stage:
  - On the edge ending N+2, the owner's rdata register loads mem_rdata and its rvalid is set for one cycle. This makes rvalid visible in cycle N+3: fixed 3-cycle grant-to-data latency.
  - The non-owner's rdata holds its value and its rvalid stays 0.
- Throughput: back-to-back grants are allowed every cycle, with up to 2 reads in flight; returns are in grant order.
- Starvation counter tx_wait, width ceil(log2(TX_MAX_WAIT+1)):
  - tx_req=1 and tx_gnt=0: increment, saturating at TX_MAX_WAIT.
  - tx_gnt=1 or tx_req=0: clear to 0.
  - tx_promoted is registered: it becomes 1 on the edge where tx_wait reaches TX_MAX_WAIT.
  - tx_promoted clears on the edge after tx_gnt=1, on tx_req=0, or on frame_start.
- hd_stall_cnt: increments each cycle with hd_req=1 and hd_gnt=0, saturates at all-ones, and clears on frame_start.
- frame_start clears tx_wait, tx_promoted and hd_stall_cnt, with clear taking precedence over increment in the same cycle.
  - frame_start does not cancel in-flight reads.
  - Grants in the frame_start cycle follow the pre-clear tx_promoted.
- Asynchronous reset mid-operation:
  - In-flight reads are discarded; no rvalid is asserted after reset release for commands issued before reset.
  - The first grant after release is legal in the first cycle rstn=1.

Test Plan:
- Reset, then hd_req=1, hd_addr=0x00123, mem model returns 0x2A5 → hd_gnt=1 in cycle 0, mem_en=1/mem_we=0/mem_addr=0x00123 in cycle 1, hd_rvalid=1 with hd_rdata=0x2A5 in cycle 3, tx_rvalid=0 throughout.
- wr_req, hd_req and tx_req all held 1 for 3 cycles → wr_gnt=1 in all 3 cycles, hd_gnt=tx_gnt=0, mem_we=1 each following cycle, hd_stall_cnt=3.
- hd_req and tx_req held 1 continuously, wr_req=0 → hd granted 8 consecutive cycles; tx_promoted=1 in cycle 8 and tx_gnt=1 in cycle 8; tx_promoted=0 in cycle 9; hd resumes in cycle 9; tx_rvalid in cycle 11.
- Alternating hd/tx grants on consecutive cycles at addresses 0x10, 0x11, 0x12, 0x13 → four rvalid pulses in cycles 3..6, routed to hd, tx, hd, tx in order, with the matching data.
- hd_stall_cnt driven to 0xFFFF, then more stall cycles → stays 0xFFFF; frame_start pulse together with a stall cycle → 0 on the next cycle.
- hd read granted in cycle 0, rstn asserted low in cycle 1 and released in cycle 2 → hd_rvalid never asserted, all outputs 0 during reset, a new grant accepted in cycle 2.
